// File: rtl/bpred_pht_sched.sv
// rtl/bpred_pht_sched.sv - single-port PHT scheduler: init sweep, lookup/update arbitration, queued RMW updates
// Optional feature macro: BP_PHT_ORDER_EN (lookups that hit a pending update wait for it to commit)
module bpred_pht_sched #(
  parameter int         INDEX_SIZE = 7,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_STATE = 2'b10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              lk_valid,
  input  logic [INDEX_SIZE-1:0]             lk_index,
  output logic                              lk_stall,
  output logic                              lk_rvalid,
  output logic                              lk_pred,
  input  logic                              upd_valid,
  input  logic [INDEX_SIZE-1:0]             upd_index,
  input  logic                              upd_taken,
  output logic                              upd_ready,
  output logic                              tbl_en,
  output logic                              tbl_we,
  output logic [INDEX_SIZE-1:0]             tbl_addr,
  output logic [1:0]                        tbl_wdata,
  input  logic [1:0]                        tbl_rdata,
  output logic                              init_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_RD, S_UPD_WR} state_t;

  state_t                state;
  logic [INDEX_SIZE-1:0] sweep;
  logic [INDEX_SIZE-1:0] q_idx [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_tkn;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [INDEX_SIZE-1:0] rmw_idx;
  logic                  rmw_tkn;
  logic [1:0]            rmw_ctr;
  logic [1:0]            new_ctr;
  logic                  rd_wait;

  logic full, empty, in_rmw, hold, lk_win, issue, commit, push, fifo_clr;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_rmw   = (state == S_UPD_RD) || (state == S_UPD_WR);
  assign fifo_clr = flush && (state != S_INIT);

`ifdef BP_PHT_ORDER_EN
  logic [FIFO_DEPTH-1:0] q_vld;
  logic                  match;

  // A lookup aimed at any queued or in-flight update index must wait for it
  always_comb begin
    match = in_rmw && (rmw_idx == lk_index);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (q_vld[i] && (q_idx[i] == lk_index)) match = 1'b1;
    end
  end

  assign hold = full | match;

  // Per-slot valid bits so the match above ignores stale slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_vld <= '0;
    end else if (fifo_clr) begin
      q_vld <= '0;
    end else begin
      if (issue) q_vld[rd_ptr] <= 1'b0;
      if (push)  q_vld[wr_ptr] <= 1'b1;
    end
  end
`else
  assign hold = full;
`endif

  assign lk_win    = (state != S_INIT) && lk_valid && !hold;
  assign lk_stall  = (state == S_INIT) || (lk_valid && hold);
  assign issue     = (state == S_IDLE) && !empty && !lk_win;
  assign commit    = (state == S_UPD_WR) && !lk_win;
  assign upd_ready = !full && init_done;
  assign push      = upd_valid && upd_ready && !flush;
  assign lk_pred   = lk_rvalid && tbl_rdata[1];
  assign pending_cnt = count + CW'(in_rmw);

  // 2-bit saturating counter step for the update being written back
  always_comb begin
    new_ctr = rmw_ctr;
    if (rmw_tkn && (rmw_ctr != 2'b11))       new_ctr = rmw_ctr + 2'd1;
    else if (!rmw_tkn && (rmw_ctr != 2'b00)) new_ctr = rmw_ctr - 2'd1;
  end

  // Table port mux: sweep, then lookup, then RMW read issue, then RMW write-back
  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = '0;
    if (state == S_INIT) begin
      if (rst) begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = sweep;
        tbl_wdata = INIT_STATE;
      end
    end else if (lk_win) begin
      tbl_en   = 1'b1;
      tbl_addr = lk_index;
    end else if (issue) begin
      tbl_en   = 1'b1;
      tbl_addr = q_idx[rd_ptr];
    end else if (commit) begin
      tbl_en    = 1'b1;
      tbl_we    = 1'b1;
      tbl_addr  = rmw_idx;
      tbl_wdata = new_ctr;
    end
  end

  // Control FSM: init sweep and the read-modify-write sequence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      sweep     <= '0;
      init_done <= 1'b0;
      rmw_idx   <= '0;
      rmw_tkn   <= 1'b0;
      rmw_ctr   <= '0;
      rd_wait   <= 1'b0;
      lk_rvalid <= 1'b0;
    end else begin
      lk_rvalid <= lk_win;
      rd_wait   <= issue;
      // Read data belongs to the RMW only on the cycle right after its read;
      // a lookup that freezes UPD_RD afterwards cannot overwrite the capture.
      if (rd_wait) rmw_ctr <= tbl_rdata;
      case (state)
        S_INIT: begin
          sweep <= sweep + 1'b1;
          if (&sweep) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (issue) begin
            rmw_idx <= q_idx[rd_ptr];
            rmw_tkn <= q_tkn[rd_ptr];
            state   <= S_UPD_RD;
          end
        end
        S_UPD_RD: begin
          if (!lk_win) state <= S_UPD_WR;
        end
        S_UPD_WR: begin
          if (commit) state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Update queue pointers and occupancy; flush drops everything not yet issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(issue);
    end
  end

  // Update queue storage
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr] <= upd_index;
      q_tkn[wr_ptr] <= upd_taken;
    end
  end

endmodule

// File: tb/tb_bpred_pht_sched.sv
// tb/tb_bpred_pht_sched.sv - directed and randomized checks of bpred_pht_sched against a transaction-level model
module tb_bpred_pht_sched;
  localparam int IW    = 4;
  localparam int NENT  = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          lk_valid = 1'b0;
  logic [IW-1:0] lk_index = '0;
  logic          upd_valid = 1'b0;
  logic [IW-1:0] upd_index = '0;
  logic          upd_taken = 1'b0;
  logic [1:0]    tbl_rdata = 2'b00;
  logic          lk_stall, lk_rvalid, lk_pred, upd_ready;
  logic          tbl_en, tbl_we, init_done;
  logic [IW-1:0] tbl_addr;
  logic [1:0]    tbl_wdata;
  logic [2:0]    pending_cnt;

  always #5 clk = ~clk;

  bpred_pht_sched #(.INDEX_SIZE(IW), .FIFO_DEPTH(DEPTH), .INIT_STATE(2'b10)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_stall(lk_stall),
    .lk_rvalid(lk_rvalid), .lk_pred(lk_pred),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata), .init_done(init_done), .pending_cnt(pending_cnt)
  );

  // Single-port table RAM with one-cycle read latency
  logic [1:0] mem [NENT];
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata <= mem[tbl_addr];
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v[1:0];
  endfunction

  // Reference model: table contents, ordered list of accepted updates (head may be in flight)
  typedef struct packed { logic [IW-1:0] idx; logic tkn; } upd_t;
  upd_t          q[$];
  logic [1:0]    mtbl [NENT];
  bit            started = 0;
  bit            mon_on = 0;
  bit            exp_rv = 0;
  logic          exp_pred = 1'b0;
  logic [IW-1:0] wr_a[$];
  logic [1:0]    wr_d[$];

  always @(negedge clk) begin
    if (mon_on) begin
      int   queued;
      bit   match;
      bit   exp_stall;
      upd_t h;
      logic [1:0] nv;
      queued = q.size() - int'(started);
      match = 0;
`ifdef BP_PHT_ORDER_EN
      foreach (q[i]) if (q[i].idx == lk_index) match = 1;
`endif
      exp_stall = lk_valid && (queued == DEPTH || match);
      check("pending_cnt", pending_cnt, q.size());
      check("upd_ready", upd_ready, queued < DEPTH);
      check("lk_stall", lk_stall, exp_stall);
      check("lk_rvalid", lk_rvalid, exp_rv);
      if (exp_rv) check("lk_pred", lk_pred, exp_pred);
      exp_rv = 0;
      if (lk_valid && !exp_stall) begin
        check("lk_port", {tbl_en, tbl_we, tbl_addr}, {1'b1, 1'b0, lk_index});
        exp_rv = 1;
        exp_pred = mtbl[lk_index][1];
      end else if (tbl_en && !tbl_we) begin
        check("rmw_rd_legal", (q.size() > 0) && !started, 1);
        if (q.size() > 0) check("rmw_rd_addr", tbl_addr, q[0].idx);
        started = 1;
      end else if (tbl_en && tbl_we) begin
        check("rmw_wr_legal", (q.size() > 0) && started, 1);
        if (q.size() > 0) begin
          h = q.pop_front();
          nv = next_ctr(mtbl[h.idx], h.tkn);
          check("rmw_wr_addr", tbl_addr, h.idx);
          check("rmw_wr_data", tbl_wdata, nv);
          mtbl[h.idx] = nv;
          wr_a.push_back(tbl_addr);
          wr_d.push_back(tbl_wdata);
        end
        started = 0;
      end
      if (flush) begin
        if (started && q.size() > 0) begin
          h = q[0];
          q.delete();
          q.push_back(h);
        end else begin
          q.delete();
        end
      end
      if (upd_valid && upd_ready && !flush) q.push_back({upd_index, upd_taken});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] idx, input logic tkn);
    cyc();
    upd_valid = 1; upd_index = idx; upd_taken = tkn;
    cyc();
    upd_valid = 0;
  endtask

  task automatic drain();
    int n;
    cyc();
    lk_valid = 0; upd_valid = 0; flush = 0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    check("drain_timeout", q.size(), 0);
    cyc();
  endtask

  task automatic run_random(input int n, input int p_lk, input int p_upd, input int p_fl);
    for (int k = 0; k < n; k++) begin
      bit lk_hold;
      bit up_hold;
      @(negedge clk);
      lk_hold = lk_valid && lk_stall;
      up_hold = upd_valid && !upd_ready;
      @(posedge clk);
      #1;
      if (!lk_hold) begin
        lk_valid = ($urandom_range(99) < p_lk);
        lk_index = IW'($urandom_range(NENT-1));
      end
      if (!up_hold) begin
        upd_valid = ($urandom_range(99) < p_upd);
        upd_index = IW'($urandom_range(NENT-1));
        upd_taken = $urandom_range(1);
      end
      flush = ($urandom_range(99) < p_fl);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < NENT; i++) mtbl[i] = 2'b10;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_lk_stall", lk_stall, 1);
    check("rst_outs", {tbl_en, tbl_we, tbl_addr, tbl_wdata, lk_rvalid, lk_pred, upd_ready, init_done, pending_cnt}, 0);

    // Reset mid-sweep restarts the sweep
    @(posedge clk); #1 rst = 1;
    repeat (5) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_mid_en", tbl_en, 0);
    @(posedge clk); #1;
    rst = 1; flush = 1; upd_valid = 1; lk_valid = 1; lk_index = 3;

    // Init sweep: one write per cycle, lookups/updates/flush held off
    for (int c = 0; c < NENT; c++) begin
      @(negedge clk);
      check("sweep_port", {tbl_en, tbl_we, tbl_addr, tbl_wdata}, {1'b1, 1'b1, IW'(c), 2'b10});
      check("sweep_hold", {init_done, lk_stall, upd_ready}, 3'b010);
    end
    cyc();
    flush = 0; upd_valid = 0; lk_valid = 0;
    @(negedge clk);
    check("init_done", {init_done, lk_stall, upd_ready, tbl_en, pending_cnt}, {4'b1010, 3'd0});
    mon_on = 1;

    // Taken update on idx 5, then saturation and four not-taken
    wr_a.delete(); wr_d.delete();
    push(5, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rmw_pending_seq", pending_cnt, (k < 3) ? 1 : 0);
    end
    drain();
    push(5, 1); drain();
    for (int k = 0; k < 4; k++) begin push(5, 0); drain(); end
    check("seq_len", wr_a.size(), 6);
    for (int k = 0; k < 6 && k < wr_a.size(); k++) begin
      check("seq_addr", wr_a[k], 5);
      check("seq_data", wr_d[k], exp_seq[k]);
    end

    // Lookup accepted while the idx 2 RMW waits in UPD_RD
    wr_a.delete(); wr_d.delete();
    cyc();
    upd_valid = 1; upd_index = 2; upd_taken = 1;
    cyc();
    upd_valid = 0;
    cyc();
    lk_valid = 1; lk_index = 7;
    cyc();
    lk_valid = 0;
    @(negedge clk);
    check("lk_in_rd_resp", {lk_rvalid, lk_pred}, 2'b11);
    drain();
    check("lk_in_rd_wr", {wr_a.size() == 1, (wr_a.size() > 0) ? wr_a[0] : 4'd0, (wr_d.size() > 0) ? wr_d[0] : 2'd0}, {1'b1, 4'd2, 2'b11});

    // Flush with three queued while the first is in UPD_RD
    wr_a.delete(); wr_d.delete();
    cyc();
    lk_valid = 1; lk_index = 15;
    upd_valid = 1; upd_index = 1; upd_taken = 0;
    cyc(); upd_index = 3; upd_taken = 1;
    cyc(); upd_index = 4; upd_taken = 1;
    cyc(); upd_valid = 0; lk_valid = 0;
    cyc(); flush = 1;
    cyc(); flush = 0;
    drain();
    check("flush_writes", {wr_a.size() == 1, (wr_a.size() > 0) ? wr_a[0] : 4'd0, (wr_d.size() > 0) ? wr_d[0] : 2'd0}, {1'b1, 4'd1, 2'b01});
    @(negedge clk);
    check("flush_pending", pending_cnt, 0);

`ifdef BP_PHT_ORDER_EN
    // Lookup to an index with a pending update waits for the write-back
    begin
      int n;
      wr_a.delete(); wr_d.delete();
      cyc();
      upd_valid = 1; upd_index = 9; upd_taken = 0;
      cyc();
      upd_valid = 0; lk_valid = 1; lk_index = 9;
      for (n = 0; n < 20; n++) begin
        @(negedge clk);
        if (!lk_stall) break;
      end
      check("ord_stalled", (n > 0) && (n < 20), 1);
      check("ord_wr_first", {wr_a.size() == 1, (wr_d.size() > 0) ? wr_d[0] : 2'd3}, {1'b1, 2'b01});
      cyc();
      lk_valid = 0;
      @(negedge clk);
      check("ord_pred", {lk_rvalid, lk_pred}, 2'b10);
      drain();
    end
`endif

    // Lookups every cycle with a steady update stream, then mixed random traffic
    run_random(60, 100, 100, 0);
    drain();
    run_random(1500, 50, 40, 2);
    drain();

    for (int i = 0; i < NENT; i++) check("final_tbl", mem[i], mtbl[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
